// File: rtl/letter_scroll_display_if.sv
// Board-side bundle for letter_scroll_display: switch/key inputs and HEX/status outputs.
// The master modport is the board (drives switches/keys); the slave modport is the display.
interface letter_scroll_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DEPTH      = 16,
  parameter int CODE_W     = 6
);
  localparam int LEN_W = $clog2(DEPTH + 1);

  logic [CODE_W-1:0]       SW;
  logic                    KEY_LOAD;
  logic                    KEY_CLEAR;
  logic                    EN_SCROLL;
  logic [8*NUM_DIGITS-1:0] HEX;
  logic [LEN_W-1:0]        LEN;
  logic                    FULL;

  modport master (
    output SW, KEY_LOAD, KEY_CLEAR, EN_SCROLL,
    input  HEX, LEN, FULL
  );

  modport slave (
    input  SW, KEY_LOAD, KEY_CLEAR, EN_SCROLL,
    output HEX, LEN, FULL
  );
endinterface

// File: rtl/letter_scroll_display.sv
// letter_scroll_display: stores a message of letter codes loaded from the switches and
// shows it on NUM_DIGITS active-low seven-segment digits, scrolling circularly when the
// message is longer than the display.
// Optional feature macro: SCROLL_DP_MARK_EN -- lights the dp of the digit showing buf[0].
module letter_scroll_display #(
  parameter int NUM_DIGITS = 4,
  parameter int DEPTH      = 16,
  parameter int CODE_W     = 6,
  parameter int TICK_DIV   = 25000000
) (
  input  logic                  CLOCK_50,
  input  logic                  RST,
  letter_scroll_display_if.slave bus
);

  localparam int LEN_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int IDX_W  = LEN_W + 1;

  // Segment pattern {g,f,e,d,c,b,a}, active-low; codes outside 1..26 are blank.
  function automatic logic [6:0] glyph(input logic [CODE_W-1:0] code);
    logic [6:0] seg;
    seg = 7'h7F;
    case (code)
      CODE_W'(1):  seg = 7'h08;  // A
      CODE_W'(2):  seg = 7'h03;  // B
      CODE_W'(3):  seg = 7'h46;  // C
      CODE_W'(4):  seg = 7'h21;  // D
      CODE_W'(5):  seg = 7'h06;  // E
      CODE_W'(6):  seg = 7'h0E;  // F
      CODE_W'(7):  seg = 7'h10;  // G
      CODE_W'(8):  seg = 7'h09;  // H
      CODE_W'(9):  seg = 7'h4F;  // I
      CODE_W'(10): seg = 7'h31;  // J
      CODE_W'(11): seg = 7'h0A;  // K
      CODE_W'(12): seg = 7'h47;  // L
      CODE_W'(13): seg = 7'h6A;  // M
      CODE_W'(14): seg = 7'h2B;  // N
      CODE_W'(15): seg = 7'h40;  // O
      CODE_W'(16): seg = 7'h0C;  // P
      CODE_W'(17): seg = 7'h18;  // Q
      CODE_W'(18): seg = 7'h2F;  // R
      CODE_W'(19): seg = 7'h12;  // S
      CODE_W'(20): seg = 7'h07;  // T
      CODE_W'(21): seg = 7'h41;  // U
      CODE_W'(22): seg = 7'h63;  // V
      CODE_W'(23): seg = 7'h15;  // W
      CODE_W'(24): seg = 7'h55;  // X
      CODE_W'(25): seg = 7'h11;  // Y
      CODE_W'(26): seg = 7'h24;  // Z
      default:     seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic                    load_prev_q;
  logic                    clear_prev_q;
  logic [CODE_W-1:0]       msg_q [DEPTH];
  logic [LEN_W-1:0]        len_q,    len_d;
  logic [PTR_W-1:0]        offset_q, offset_d;
  logic [TICK_W-1:0]       tick_q,   tick_d;
  logic [8*NUM_DIGITS-1:0] hex_q,    hex_d;

  logic load_edge;
  logic clear_edge;
  logic full;
  logic wr_en;
  logic scroll_active;
  logic tick_term;

  assign load_edge     = bus.KEY_LOAD  & ~load_prev_q;
  assign clear_edge    = bus.KEY_CLEAR & ~clear_prev_q;
  assign full          = (len_q == LEN_W'(DEPTH));
  // Clear beats a simultaneous load; a full buffer silently drops the write.
  assign wr_en         = load_edge & ~clear_edge & ~full;
  assign scroll_active = bus.EN_SCROLL && (len_q > LEN_W'(NUM_DIGITS));
  assign tick_term     = (tick_q == TICK_W'(TICK_DIV - 1));

  // Next length, scroll offset and tick counter.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned
    // (which would infer a latch); blocking '=' is correct here, '<=' belongs in always_ff.
    len_d    = len_q;
    offset_d = offset_q;
    tick_d   = tick_q;
    if (clear_edge) begin
      len_d    = '0;
      offset_d = '0;
      tick_d   = '0;
    end else begin
      if (wr_en) begin
        len_d = len_q + 1'b1;
      end
      // Wrap compare uses the pre-load length even if a load lands in the same cycle.
      if (scroll_active) begin
        if (tick_term) begin
          tick_d   = '0;
          offset_d = ((LEN_W'(offset_q) + 1'b1) == len_q) ? '0 : offset_q + 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end else begin
        // Idle or frozen: offset holds, counting restarts from 0 when scrolling resumes.
        tick_d = '0;
      end
    end
  end

  // Message buffer write port.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: the buffer has no reset; entries at or beyond LEN are never displayed, so
    // their power-up contents do not matter and the RAM can map to plain storage.
    if (wr_en) begin
      msg_q[len_q[PTR_W-1:0]] <= bus.SW;
    end
  end

  // Window mapping: digit k shows buf[(offset + NUM_DIGITS-1-k) mod LEN].
  logic [PTR_W-1:0] eff_off;
  logic [IDX_W-1:0] idx;
  logic             in_view;

  always_comb begin
    hex_d   = '1;
    idx     = '0;
    in_view = 1'b0;
    eff_off = (len_q <= LEN_W'(NUM_DIGITS)) ? '0 : offset_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      idx     = IDX_W'(eff_off) + IDX_W'(NUM_DIGITS - 1 - k);
      in_view = 1'b0;
      if (len_q != '0) begin
        if (len_q <= LEN_W'(NUM_DIGITS)) begin
          // Short message: left-justified, no wrap, unused right digits stay blank.
          in_view = (idx < IDX_W'(len_q));
        end else begin
          // idx < 2*LEN here, so one conditional subtract is a full modulo.
          in_view = 1'b1;
          if (idx >= IDX_W'(len_q)) begin
            idx = idx - IDX_W'(len_q);
          end
        end
      end
      if (in_view) begin
`ifdef SCROLL_DP_MARK_EN
        hex_d[8*k +: 8] = {(idx != '0), glyph(msg_q[idx[PTR_W-1:0]])};
`else
        hex_d[8*k +: 8] = {1'b1, glyph(msg_q[idx[PTR_W-1:0]])};
`endif
      end
    end
  end

  // State and output registers; edge detectors reset high so a held key does not fire.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      load_prev_q  <= 1'b1;
      clear_prev_q <= 1'b1;
      len_q        <= '0;
      offset_q     <= '0;
      tick_q       <= '0;
      hex_q        <= '1;
    end else begin
      load_prev_q  <= bus.KEY_LOAD;
      clear_prev_q <= bus.KEY_CLEAR;
      len_q        <= len_d;
      offset_q     <= offset_d;
      tick_q       <= tick_d;
      hex_q        <= hex_d;
    end
  end

  assign bus.HEX  = hex_q;
  assign bus.LEN  = len_q;
  assign bus.FULL = full;

endmodule

// File: tb/tb_letter_scroll_display.sv
// Directed bench for letter_scroll_display with NUM_DIGITS=4, DEPTH=8, TICK_DIV=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_letter_scroll_display;

  localparam int ND = 4;
  localparam int DP = 8;
  localparam int CW = 6;
  localparam int TD = 4;

`ifdef SCROLL_DP_MARK_EN
  localparam logic [31:0] HEX_A      = 32'h08FFFFFF;
  localparam logic [31:0] HEX_AB     = 32'h0883FFFF;
  localparam logic [31:0] HEX_BLANK2 = 32'h7FFFFFFF;
  localparam logic [31:0] STEPS [5]  = '{32'h0883C6A1, 32'h83C6A186, 32'hC6A18608,
                                         32'hA1860883, 32'h860883C6};
`else
  localparam logic [31:0] HEX_A      = 32'h88FFFFFF;
  localparam logic [31:0] HEX_AB     = 32'h8883FFFF;
  localparam logic [31:0] HEX_BLANK2 = 32'hFFFFFFFF;
  localparam logic [31:0] STEPS [5]  = '{32'h8883C6A1, 32'h83C6A186, 32'hC6A18688,
                                         32'hA1868883, 32'h868883C6};
`endif
  localparam logic [31:0] HEX_EFGH  = 32'h868E9089;
  localparam logic [31:0] HEX_BLANK = 32'hFFFFFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  letter_scroll_display_if #(.NUM_DIGITS(ND), .DEPTH(DP), .CODE_W(CW)) bus ();

  letter_scroll_display #(
    .NUM_DIGITS(ND), .DEPTH(DP), .CODE_W(CW), .TICK_DIV(TD)
  ) dut (
    .CLOCK_50(clk),
    .RST     (rst),
    .bus     (bus)
  );

  // One press: strobe high for a cycle, then low; returns after HEX reflects the load.
  task automatic press(input logic [CW-1:0] code);
    bus.SW       = code;
    bus.KEY_LOAD = 1'b1;
    @(negedge clk);
    bus.KEY_LOAD = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_msg();
    bus.KEY_CLEAR = 1'b1;
    @(negedge clk);
    bus.KEY_CLEAR = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (bus.HEX !== HEX_BLANK) begin bad++; $display("FAIL por_hex got %h want %h", bus.HEX, HEX_BLANK); end
    total++; if (bus.LEN !== 4'd0) begin bad++; $display("FAIL por_len got %0d want 0", bus.LEN); end
    rst = 1'b0;
    press(6'd1);
    press(6'd2);
    // Asynchronous assertion between edges, with the load key held through release.
    #2;
    rst          = 1'b1;
    bus.KEY_LOAD = 1'b1;
    bus.SW       = 6'd3;
    #1;
    total++; if (bus.HEX !== HEX_BLANK) begin bad++; $display("FAIL async_hex got %h want %h", bus.HEX, HEX_BLANK); end
    total++; if (bus.LEN !== 4'd0) begin bad++; $display("FAIL async_len got %0d want 0", bus.LEN); end
    total++; if (bus.FULL !== 1'b0) begin bad++; $display("FAIL async_full got %b want 0", bus.FULL); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.LEN !== 4'd0) begin bad++; $display("FAIL held_key_len got %0d want 0", bus.LEN); end
    bus.KEY_LOAD = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.LEN !== 4'd0) begin bad++; $display("FAIL release_len got %0d want 0", bus.LEN); end
  endtask

  task automatic test_load_ab();
    press(6'd1);
    total++; if (bus.LEN !== 4'd1) begin bad++; $display("FAIL len_a got %0d want 1", bus.LEN); end
    total++; if (bus.HEX !== HEX_A) begin bad++; $display("FAIL hex_a got %h want %h", bus.HEX, HEX_A); end
    bus.SW       = 6'd2;
    bus.KEY_LOAD = 1'b1;
    @(negedge clk);
    // One edge after the load: LEN already updated, HEX still the previous picture.
    total++; if (bus.LEN !== 4'd2) begin bad++; $display("FAIL len_b got %0d want 2", bus.LEN); end
    total++; if (bus.HEX !== HEX_A) begin bad++; $display("FAIL hex_latency got %h want %h", bus.HEX, HEX_A); end
    bus.KEY_LOAD = 1'b0;
    @(negedge clk);
    total++; if (bus.HEX !== HEX_AB) begin bad++; $display("FAIL hex_ab got %h want %h", bus.HEX, HEX_AB); end
    total++; if (bus.FULL !== 1'b0) begin bad++; $display("FAIL full_ab got %b want 0", bus.FULL); end
  endtask

  task automatic test_scroll();
    press(6'd3);
    press(6'd4);
    press(6'd5);
    total++; if (bus.LEN !== 4'd5) begin bad++; $display("FAIL len_5 got %0d want 5", bus.LEN); end
    total++; if (bus.HEX !== STEPS[0]) begin bad++; $display("FAIL frozen_start got %h want %h", bus.HEX, STEPS[0]); end
    bus.EN_SCROLL = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (bus.HEX !== STEPS[0]) begin bad++; $display("FAIL pre_step got %h want %h", bus.HEX, STEPS[0]); end
    @(negedge clk);
    total++; if (bus.HEX !== STEPS[1]) begin bad++; $display("FAIL step_1 got %h want %h", bus.HEX, STEPS[1]); end
    for (int i = 2; i <= 5; i++) begin
      repeat (TD) @(negedge clk);
      total++;
      if (bus.HEX !== STEPS[i % 5]) begin
        bad++; $display("FAIL step_%0d got %h want %h", i, bus.HEX, STEPS[i % 5]);
      end
    end
  endtask

  task automatic test_freeze();
    // Counter is one cycle into the current step here.
    bus.EN_SCROLL = 1'b0;
    repeat (9) @(negedge clk);
    total++; if (bus.HEX !== STEPS[0]) begin bad++; $display("FAIL frozen_hex got %h want %h", bus.HEX, STEPS[0]); end
    bus.EN_SCROLL = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (bus.HEX !== STEPS[0]) begin bad++; $display("FAIL resume_early got %h want %h", bus.HEX, STEPS[0]); end
    @(negedge clk);
    total++; if (bus.HEX !== STEPS[1]) begin bad++; $display("FAIL resume_step got %h want %h", bus.HEX, STEPS[1]); end
    bus.EN_SCROLL = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full();
    clear_msg();
    total++; if (bus.LEN !== 4'd0) begin bad++; $display("FAIL clear_len got %0d want 0", bus.LEN); end
    for (int c = 1; c <= 7; c++) press(6'(c));
    total++; if (bus.FULL !== 1'b0) begin bad++; $display("FAIL full_at_7 got %b want 0", bus.FULL); end
    press(6'd8);
    total++; if (bus.FULL !== 1'b1) begin bad++; $display("FAIL full_at_8 got %b want 1", bus.FULL); end
    press(6'd26);
    total++; if (bus.LEN !== 4'd8) begin bad++; $display("FAIL overflow_len got %0d want 8", bus.LEN); end
    total++; if (bus.FULL !== 1'b1) begin bad++; $display("FAIL overflow_full got %b want 1", bus.FULL); end
    total++; if (bus.HEX !== STEPS[0]) begin bad++; $display("FAIL overflow_hex got %h want %h", bus.HEX, STEPS[0]); end
    // Scroll four steps to expose entries 4..7 and confirm the tail was not overwritten.
    bus.EN_SCROLL = 1'b1;
    repeat (4 * TD + 1) @(negedge clk);
    total++; if (bus.HEX !== HEX_EFGH) begin bad++; $display("FAIL tail_hex got %h want %h", bus.HEX, HEX_EFGH); end
    bus.EN_SCROLL = 1'b0;
    clear_msg();
    press(6'd0);
    press(6'd40);
    total++; if (bus.LEN !== 4'd2) begin bad++; $display("FAIL blank_len got %0d want 2", bus.LEN); end
    total++; if (bus.HEX !== HEX_BLANK2) begin bad++; $display("FAIL blank_hex got %h want %h", bus.HEX, HEX_BLANK2); end
  endtask

  task automatic test_clear_load();
    clear_msg();
    for (int c = 1; c <= 5; c++) press(6'(c));
    bus.EN_SCROLL = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (bus.HEX !== STEPS[1]) begin bad++; $display("FAIL pre_clear got %h want %h", bus.HEX, STEPS[1]); end
    bus.EN_SCROLL = 1'b0;
    bus.SW        = 6'd9;
    bus.KEY_CLEAR = 1'b1;
    bus.KEY_LOAD  = 1'b1;
    @(negedge clk);
    total++; if (bus.LEN !== 4'd0) begin bad++; $display("FAIL clear_wins_len got %0d want 0", bus.LEN); end
    bus.KEY_CLEAR = 1'b0;
    bus.KEY_LOAD  = 1'b0;
    @(negedge clk);
    total++; if (bus.HEX !== HEX_BLANK) begin bad++; $display("FAIL clear_wins_hex got %h want %h", bus.HEX, HEX_BLANK); end
    // Offset must have been reset: reloading five letters starts the window at A again.
    for (int c = 1; c <= 5; c++) press(6'(c));
    total++; if (bus.LEN !== 4'd5) begin bad++; $display("FAIL reload_len got %0d want 5", bus.LEN); end
    total++; if (bus.HEX !== STEPS[0]) begin bad++; $display("FAIL reload_hex got %h want %h", bus.HEX, STEPS[0]); end
  endtask

  initial begin
    bus.SW        = '0;
    bus.KEY_LOAD  = 1'b0;
    bus.KEY_CLEAR = 1'b0;
    bus.EN_SCROLL = 1'b0;
    test_reset();
    test_load_ab();
    test_scroll();
    test_freeze();
    test_full();
    test_clear_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
